vita49_unpack_mc: RTL

//  Multi-stream, timed-release VITA-49 signal-data unpacker. Sits between the DMA/VITA ingress stream and sample sinks.

---
 rtl/vita49_unpack_mc.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/vita49_unpack_mc.sv
// VITA-49 signal-data unpacker: strips the 5-word header, routes payload by stream ID,
// optionally holds packets until their timestamp, and keeps saturating error counters.
module vita49_unpack_mc #(
    parameter int unsigned NUM_STREAMS = 4,
    parameter int unsigned TDEST_W     = 2
) (
    input  logic                      AXIS_ACLK,
    input  logic                      AXIS_ARESET,
    input  logic [31:0]               S_AXIS_TDATA,
    input  logic                      S_AXIS_TVALID,
    input  logic                      S_AXIS_TLAST,
    output logic                      S_AXIS_TREADY,
    output logic [31:0]               M_AXIS_TDATA,
    output logic                      M_AXIS_TVALID,
    output logic                      M_AXIS_TLAST,
    output logic [TDEST_W-1:0]        M_AXIS_TDEST,
    input  logic                      M_AXIS_TREADY,
    input  logic [31:0]               ctrl,
    output logic [31:0]               status,
    input  logic [32*NUM_STREAMS-1:0] streamID,
    input  logic [NUM_STREAMS-1:0]    stream_en,
    input  logic [31:0]               timestamp_sec,
    input  logic [63:0]               timestamp_fsec
);

    localparam int unsigned SLOT_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

    typedef enum logic [3:0] {
        S_HDR, S_SID, S_TSI, S_TSFH, S_TSFL, S_WAIT, S_PAY, S_DROP, S_PASS
    } state_t;

    state_t             state_q, state_n;
    logic [3:0]         cnt_q;
    logic [15:0]        rem_q;
    logic [SLOT_W-1:0]  slot_q;
    logic [31:0]        tsi_q, tsfh_q, tsfl_q;
    logic               first_q;
    logic [3:0]         last_q [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] valid_q;
    logic [7:0]         late_q, nomatch_q, seq_q;
    logic [6:0]         len_q;

    logic               run_c, hs, hit_c, hdr_bad_c, seq_bad_c, t_lt_l_c, t_gt_l_c;
    logic [SLOT_W-1:0]  idx_c;
    logic               s_ready_c, m_valid_c, m_last_c;
    logic [31:0]        m_data_c;
    logic [TDEST_W-1:0] m_dest_c;
    logic               ld_hdr, ld_sid, ld_tsi, ld_tsfh, ld_tsfl, dec_rem, seq_upd;
    logic               inc_len, inc_nomatch, inc_seq, inc_late;
    logic               ctrl_unused;

    assign ctrl_unused = &{1'b0, ctrl[31:4]};

    // Any reset forces the handshake outputs low and the data outputs to zero
    assign run_c     = !AXIS_ARESET && !ctrl[1];
    assign hdr_bad_c = (S_AXIS_TDATA[31:28] != 4'h1) || (S_AXIS_TDATA[15:0] < 16'd6);
    assign seq_bad_c = valid_q[slot_q] && (cnt_q != 4'(last_q[slot_q] + 4'd1));
    assign t_lt_l_c  = {tsi_q, tsfh_q, tsfl_q} < {timestamp_sec, timestamp_fsec};
    assign t_gt_l_c  = {tsi_q, tsfh_q, tsfl_q} > {timestamp_sec, timestamp_fsec};

    // Lowest enabled slot with a matching ID wins
    always_comb begin
        hit_c = 1'b0;
        idx_c = '0;
        for (int i = int'(NUM_STREAMS) - 1; i >= 0; i--) begin
            if (stream_en[i] && (S_AXIS_TDATA == streamID[32*i +: 32])) begin
                hit_c = 1'b1;
                idx_c = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        state_n     = state_q;
        s_ready_c   = 1'b0;
        m_valid_c   = 1'b0;
        m_last_c    = 1'b0;
        m_data_c    = '0;
        m_dest_c    = '0;
        hs          = 1'b0;
        ld_hdr      = 1'b0;
        ld_sid      = 1'b0;
        ld_tsi      = 1'b0;
        ld_tsfh     = 1'b0;
        ld_tsfl     = 1'b0;
        dec_rem     = 1'b0;
        seq_upd     = 1'b0;
        inc_len     = 1'b0;
        inc_nomatch = 1'b0;
        inc_seq     = 1'b0;
        inc_late    = 1'b0;
        unique case (state_q)
            S_HDR: begin
                if (ctrl[0] && ctrl[3]) begin
                    s_ready_c = run_c && M_AXIS_TREADY;
                    m_valid_c = run_c && S_AXIS_TVALID;
                    m_data_c  = run_c ? S_AXIS_TDATA : '0;
                    m_last_c  = run_c && S_AXIS_TLAST;
                    hs        = S_AXIS_TVALID && s_ready_c;
                    if (hs && !S_AXIS_TLAST) state_n = S_PASS;
                end else if (ctrl[0]) begin
                    s_ready_c = run_c;
                    hs        = S_AXIS_TVALID && s_ready_c;
                    if (hs) begin
                        if (hdr_bad_c || S_AXIS_TLAST) begin
                            inc_len = 1'b1;
                            state_n = S_AXIS_TLAST ? S_HDR : S_DROP;
                        end else begin
                            ld_hdr  = 1'b1;
                            state_n = S_SID;
                        end
                    end
                end
            end
            S_SID: begin
                s_ready_c = run_c && ctrl[0];
                hs        = S_AXIS_TVALID && s_ready_c;
                if (hs) begin
                    ld_sid = 1'b1;
                    if (S_AXIS_TLAST) begin
                        inc_len = 1'b1;
                        state_n = S_HDR;
                    end else if (!hit_c) begin
                        inc_nomatch = 1'b1;
                        state_n     = S_DROP;
                    end else begin
                        state_n = S_TSI;
                    end
                end
            end
            S_TSI, S_TSFH: begin
                s_ready_c = run_c && ctrl[0];
                hs        = S_AXIS_TVALID && s_ready_c;
                if (hs) begin
                    ld_tsi  = (state_q == S_TSI);
                    ld_tsfh = (state_q == S_TSFH);
                    if (S_AXIS_TLAST) begin
                        inc_len = 1'b1;
                        state_n = S_HDR;
                    end else begin
                        state_n = (state_q == S_TSI) ? S_TSFH : S_TSFL;
                    end
                end
            end
            S_TSFL: begin
                s_ready_c = run_c && ctrl[0];
                hs        = S_AXIS_TVALID && s_ready_c;
                if (hs) begin
                    ld_tsfl = 1'b1;
                    if (S_AXIS_TLAST) begin
                        inc_len = 1'b1;
                        state_n = S_HDR;
                    end else begin
                        seq_upd = 1'b1;
                        inc_seq = seq_bad_c;
                        state_n = ctrl[2] ? S_WAIT : S_PAY;
                    end
                end
            end
            S_WAIT: begin
                // Lateness is judged only on entry; afterwards just wait for local time
                if (first_q && t_lt_l_c) begin
                    inc_late = 1'b1;
                    state_n  = S_DROP;
                end else if (!t_gt_l_c) begin
                    state_n = S_PAY;
                end
            end
            S_PAY: begin
                s_ready_c = run_c && M_AXIS_TREADY;
                m_valid_c = run_c && S_AXIS_TVALID;
                m_data_c  = run_c ? S_AXIS_TDATA : '0;
                m_dest_c  = run_c ? TDEST_W'(slot_q) : '0;
                m_last_c  = run_c && ((rem_q == 16'd1) || S_AXIS_TLAST);
                hs        = S_AXIS_TVALID && s_ready_c;
                if (hs) begin
                    dec_rem = 1'b1;
                    if (S_AXIS_TLAST) begin
                        inc_len = (rem_q != 16'd1);
                        state_n = S_HDR;
                    end else if (rem_q == 16'd1) begin
                        inc_len = 1'b1;
                        state_n = S_DROP;
                    end
                end
            end
            S_DROP: begin
                s_ready_c = run_c;
                hs        = S_AXIS_TVALID && s_ready_c;
                if (hs && S_AXIS_TLAST) state_n = S_HDR;
            end
            S_PASS: begin
                s_ready_c = run_c && M_AXIS_TREADY;
                m_valid_c = run_c && S_AXIS_TVALID;
                m_data_c  = run_c ? S_AXIS_TDATA : '0;
                m_last_c  = run_c && S_AXIS_TLAST;
                hs        = S_AXIS_TVALID && s_ready_c;
                if (hs && S_AXIS_TLAST) state_n = S_HDR;
            end
            default: state_n = S_HDR;
        endcase
    end

    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            state_q   <= S_HDR;
            cnt_q     <= '0;
            rem_q     <= '0;
            slot_q    <= '0;
            tsi_q     <= '0;
            tsfh_q    <= '0;
            tsfl_q    <= '0;
            first_q   <= 1'b0;
            valid_q   <= '0;
            late_q    <= '0;
            nomatch_q <= '0;
            seq_q     <= '0;
            len_q     <= '0;
            for (int i = 0; i < int'(NUM_STREAMS); i++) last_q[i] <= '0;
        end else if (ctrl[1]) begin
            state_q   <= S_HDR;
            first_q   <= 1'b0;
            valid_q   <= '0;
            late_q    <= '0;
            nomatch_q <= '0;
            seq_q     <= '0;
            len_q     <= '0;
        end else begin
            state_q <= state_n;
            first_q <= (state_q != S_WAIT);
            if (ld_hdr) begin
                cnt_q <= S_AXIS_TDATA[19:16];
                rem_q <= S_AXIS_TDATA[15:0] - 16'd5;
            end
            if (dec_rem) rem_q <= rem_q - 16'd1;
            if (ld_sid)  slot_q <= idx_c;
            if (ld_tsi)  tsi_q  <= S_AXIS_TDATA;
            if (ld_tsfh) tsfh_q <= S_AXIS_TDATA;
            if (ld_tsfl) tsfl_q <= S_AXIS_TDATA;
            if (seq_upd) begin
                last_q[slot_q]  <= cnt_q;
                valid_q[slot_q] <= 1'b1;
            end
            if (inc_len && (len_q != '1))         len_q     <= len_q + 7'd1;
            if (inc_nomatch && (nomatch_q != '1)) nomatch_q <= nomatch_q + 8'd1;
            if (inc_seq && (seq_q != '1))         seq_q     <= seq_q + 8'd1;
            if (inc_late && (late_q != '1))       late_q    <= late_q + 8'd1;
        end
    end

    assign S_AXIS_TREADY = s_ready_c;
    assign M_AXIS_TDATA  = m_data_c;
    assign M_AXIS_TVALID = m_valid_c;
    assign M_AXIS_TLAST  = m_last_c;
    assign M_AXIS_TDEST  = m_dest_c;
    assign status        = {late_q, nomatch_q, seq_q, len_q, (state_q != S_HDR)};

endmodule
